// File: rtl/shift_seq.sv
// shift_seq: sequences an external 8-bit shifter through load, amt shift cycles and a result capture.
// Optional abort input is compiled in when SHIFT_SEQ_ABORT_EN is defined.
module shift_seq (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       dir_i,
  input  logic       mode_i,
  input  logic [2:0] amt_i,
  input  logic [7:0] din_i,
  input  logic       carry_in_i,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic       abort_i,
`endif
  output logic [1:0] sh_s_o,
  output logic       sh_m_o,
  output logic       sh_co_o,
  output logic [7:0] sh_d_o,
  input  logic [7:0] sh_q_i,
  input  logic       sh_cn_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] result_o,
  output logic       cout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Request captured at acceptance; everything downstream works from this copy.
  typedef struct packed {
    logic       dir;
    logic       mode;
    logic [2:0] amt;
    logic [7:0] din;
    logic       cin;
  } req_t;

  state_e     state_q, state_d;
  req_t       req_q, req_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] result_q, result_d;
  logic       cout_q, cout_d;
  logic       abort_w;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= 3'd0;
      done_q   <= 1'b0;
      result_q <= 8'h00;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          req_d.dir  = dir_i;
          req_d.mode = mode_i;
          req_d.amt  = amt_i;
          req_d.din  = din_i;
          req_d.cin  = carry_in_i;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (abort_w) begin
          state_d = IDLE;
        end else if (req_q.amt == 3'd0) begin
          state_d = DONE;
        end else begin
          cnt_d   = req_q.amt;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort_w) begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = DONE;
        end
      end
      DONE: begin
        // With no shifts the shifter carry was never driven by a shift, so use the operand carry.
        result_d = sh_q_i;
        cout_d   = (req_q.amt == 3'd0) ? req_q.cin : sh_cn_i;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sh_s_o = 2'b00;
    unique case (state_q)
      LOAD:    sh_s_o = 2'b11;
      SHIFT:   sh_s_o = req_q.dir ? 2'b01 : 2'b10;
      default: sh_s_o = 2'b00;
    endcase
  end

  assign sh_m_o   = req_q.mode;
  assign sh_co_o  = req_q.cin;
  assign sh_d_o   = req_q.din;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: table vectors, directed corner sequences and random ops against a rotate model.
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, dir = 1'b0, mode = 1'b0, carry_in = 1'b0, abort = 1'b0;
  logic [2:0] amt = 3'd0;
  logic [7:0] din = 8'h00;
  logic [1:0] sh_s;
  logic       sh_m, sh_co, sh_cn, busy, done, cout;
  logic [7:0] sh_d, sh_q, result;

  int nvec = 0;
  int nerr = 0;

  shift_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .dir_i(dir), .mode_i(mode),
    .amt_i(amt), .din_i(din), .carry_in_i(carry_in),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort_i(abort),
`endif
    .sh_s_o(sh_s), .sh_m_o(sh_m), .sh_co_o(sh_co), .sh_d_o(sh_d),
    .sh_q_i(sh_q), .sh_cn_i(sh_cn), .busy_o(busy), .done_o(done),
    .result_o(result), .cout_o(cout)
  );

  always #5 clk = ~clk;

  // Downstream shifter the sequencer drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= 8'h00;
      sh_cn <= 1'b0;
    end else begin
      case (sh_s)
        2'b11: begin sh_q <= sh_d; sh_cn <= sh_co; end
        2'b10: begin sh_q <= {(sh_m ? sh_cn : sh_q[0]), sh_q[7:1]}; sh_cn <= sh_q[0]; end
        2'b01: begin sh_q <= {sh_q[6:0], (sh_m ? sh_cn : sh_q[7])}; sh_cn <= sh_q[7]; end
        default: ;
      endcase
    end
  end

  // Whole-operation reference: 8-bit rotate, or 9-bit rotate of {carry,data}.
  function automatic void ref_op(input logic d, input logic m, input logic [2:0] a,
                                 input logic [7:0] x, input logic c,
                                 output logic [7:0] r, output logic co);
    logic [15:0] w8;
    logic [17:0] w9;
    if (!m) begin
      w8 = {x, x};
      if (d) begin w8 = w8 << a; r = w8[15:8]; co = r[0]; end
      else   begin w8 = w8 >> a; r = w8[7:0];  co = r[7]; end
      if (a == 3'd0) co = c;
    end else begin
      w9 = {c, x, c, x};
      if (d) begin w9 = w9 << a; {co, r} = w9[17:9]; end
      else   begin w9 = w9 >> a; {co, r} = w9[8:0];  end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_sh_s"}, int'(sh_s), 0);
    chk({nm, "_sh_m"}, int'(sh_m), 0);
    chk({nm, "_sh_co"}, int'(sh_co), 0);
    chk({nm, "_sh_d"}, int'(sh_d), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_result"}, int'(result), 0);
    chk({nm, "_cout"}, int'(cout), 0);
  endtask

  // Caller is just past a negedge; start is seen at the next posedge (E0).
  task automatic do_op(input logic d, input logic m, input logic [2:0] a, input logic [7:0] x,
                       input logic c, input logic [7:0] er, input logic ec);
    int  k, nl, nr;
    bit  found;
    dir = d; mode = m; amt = a; din = x; carry_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dir = 1'($urandom); mode = 1'($urandom); amt = 3'($urandom);
    din = 8'($urandom); carry_in = 1'($urandom);
    nl = 0; nr = 0; k = 0; found = 0;
    while (!found && k < 12) begin
      @(negedge clk);
      if (k == 0) begin
        chk("load_cmd", int'(sh_s), 3);
        chk("busy_in_op", int'(busy), 1);
      end
      if (k == int'(a) + 1) chk("done_state_cmd", int'(sh_s), 0);
      if (sh_s == 2'b10) nr++;
      if (sh_s == 2'b01) nl++;
      if (done) found = 1; else k++;
    end
    chk("done_latency", k, int'(a) + 2);
    chk("shift_cycles", d ? nl : nr, int'(a));
    chk("wrong_dir_cycles", d ? nr : nl, 0);
    chk("busy_at_done", int'(busy), 0);
    chk("result", int'(result), int'(er));
    chk("cout", int'(cout), int'(ec));
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("result_hold", int'(result), int'(er));
    chk("cout_hold", int'(cout), int'(ec));
  endtask

  typedef struct {
    logic       d, m;
    logic [2:0] a;
    logic [7:0] x;
    logic       c;
    logic [7:0] er;
    logic       ec;
  } vec_t;

  initial begin
    vec_t       tbl[8];
    logic [7:0] er1, er2, r0;
    logic       ec1, ec2, c0;
    logic       rd, rm, rc;
    logic [2:0] ra;
    logic [7:0] rx;
    int         nd;

    tbl[0] = '{1'b0, 1'b0, 3'd1, 8'h81, 1'b0, 8'hC0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 3'd3, 8'h81, 1'b0, 8'h0C, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 3'd0, 8'h5A, 1'b1, 8'h5A, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 3'd1, 8'h01, 1'b1, 8'h80, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 3'd2, 8'h80, 1'b0, 8'h01, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 3'd7, 8'h01, 1'b1, 8'h02, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 3'd7, 8'hFF, 1'b0, 8'hFD, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 3'd4, 8'hA5, 1'b0, 8'h5A, 1'b0};

    // Reset with a request pending: nothing may start.
    start = 1'b1; din = 8'hFF; amt = 3'd3; carry_in = 1'b1; mode = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      do_op(tbl[i].d, tbl[i].m, tbl[i].a, tbl[i].x, tbl[i].c, tbl[i].er, tbl[i].ec);

    // Start held high across two ops, plus a stray pulse while busy.
    ref_op(1'b0, 1'b1, 3'd2, 8'h3C, 1'b1, er1, ec1);
    ref_op(1'b1, 1'b0, 3'd1, 8'h96, 1'b0, er2, ec2);
    dir = 1'b0; mode = 1'b1; amt = 3'd2; din = 8'h3C; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    dir = 1'b1; mode = 1'b0; amt = 3'd1; din = 8'h96; carry_in = 1'b0;
    nd = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 5) start = 1'b0;
      if (k == 6) start = 1'b1;
      if (k == 7) start = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) begin
          chk("b2b_first_done_at", k, 4);
          chk("b2b_first_result", int'(result), int'(er1));
          chk("b2b_first_cout", int'(cout), int'(ec1));
        end else begin
          chk("b2b_next_done_at", k, 8);
          chk("b2b_next_result", int'(result), int'(er2));
          chk("b2b_next_cout", int'(cout), int'(ec2));
        end
      end
    end
    chk("b2b_done_count", nd, 2);

    // Asynchronous reset in the middle of a 5-shift op.
    dir = 1'b1; mode = 1'b1; amt = 3'd5; din = 8'hC3; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_reset", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ref_op(1'b0, 1'b0, 3'd2, 8'h0F, 1'b0, er1, ec1);
    do_op(1'b0, 1'b0, 3'd2, 8'h0F, 1'b0, er1, ec1);

`ifdef SHIFT_SEQ_ABORT_EN
    // Abort in the second shift cycle of a 6-shift op.
    r0 = result; c0 = cout;
    dir = 1'b1; mode = 1'b0; amt = 3'd6; din = 8'h11; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sh_s", int'(sh_s), 0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_result_kept", int'(result), int'(r0));
    chk("abort_cout_kept", int'(cout), int'(c0));
    ref_op(1'b1, 1'b1, 3'd3, 8'h42, 1'b1, er1, ec1);
    do_op(1'b1, 1'b1, 3'd3, 8'h42, 1'b1, er1, ec1);
`endif

    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom); rm = 1'($urandom); ra = 3'($urandom);
      rx = 8'($urandom); rc = 1'($urandom);
      ref_op(rd, rm, ra, rx, rc, er1, ec1);
      do_op(rd, rm, ra, rx, rc, er1, ec1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
